// File: rtl/conv_tap_if.sv
// Tap-descriptor bus between the convolution tap scheduler and the PE array / buffers.
// The scheduler drives the descriptor (master); the consumer returns tap_ready_i (slave).
interface conv_tap_if #(
  parameter int unsigned K_R   = 3,
  parameter int unsigned K_S   = 3,
  parameter int unsigned DIM_W = 7
);
  localparam int unsigned AW = $clog2(K_R * K_S) + 1;
  localparam int unsigned RW = $clog2(K_R) + 1;
  localparam int unsigned SW = $clog2(K_S) + 1;

  logic             tap_valid_o;
  logic             tap_ready_i;
  logic [AW-1:0]    w_addr_o;
  logic [RW-1:0]    kr_o;
  logic [SW-1:0]    ks_o;
  logic [DIM_W-1:0] oy_o;
  logic [DIM_W-1:0] ox_o;
  logic             last_tap_o;
  logic             last_pix_o;

  modport master (
    output tap_valid_o, w_addr_o, kr_o, ks_o, oy_o, ox_o, last_tap_o, last_pix_o,
    input  tap_ready_i
  );

  modport slave (
    input  tap_valid_o, w_addr_o, kr_o, ks_o, oy_o, ox_o, last_tap_o, last_pix_o,
    output tap_ready_i
  );
endinterface

// File: rtl/conv_tap_scheduler.sv
// Convolution tap scheduler: walks ks, kr, ox, oy (fastest first) over an
// out_h x out_w output map, issuing one tap descriptor per handshake.
// Optional feature macro: CONV_TAP_SCHED_STALL_CNT_EN adds stall_cnt_o, a
// saturating count of RUN cycles where the descriptor was offered but not taken.
module conv_tap_scheduler #(
  parameter int unsigned K_R   = 3,
  parameter int unsigned K_S   = 3,
  parameter int unsigned DIM_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_async_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [DIM_W-1:0] out_h_i,
  input  logic [DIM_W-1:0] out_w_i,
  conv_tap_if.master       tap_bus,
  output logic             busy_o,
  output logic             done_o
`ifdef CONV_TAP_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt_o
`endif
);
  localparam int unsigned AW = $clog2(K_R * K_S) + 1;
  localparam int unsigned RW = $clog2(K_R) + 1;
  localparam int unsigned SW = $clog2(K_S) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RW-1:0]    r_kr;
  logic [SW-1:0]    r_ks;
  logic [DIM_W-1:0] r_oy;
  logic [DIM_W-1:0] r_ox;
  logic [DIM_W-1:0] r_h;
  logic [DIM_W-1:0] r_w;
  logic [AW-1:0]    r_waddr;

  logic w_run;
  logic w_hs;
  logic w_start_ok;
  logic w_dims_ok;
  logic w_kr_end;
  logic w_ks_end;
  logic w_ox_end;
  logic w_oy_end;
  logic w_last_tap;
  logic w_last_pix;

  // Handshake / boundary decodes from registered state.
  always_comb begin
    w_run      = (r_state == ST_RUN);
    w_hs       = w_run & tap_bus.tap_ready_i;
    w_start_ok = (r_state == ST_IDLE) & start_i & ~abort_i;
    w_dims_ok  = (|out_h_i) & (|out_w_i);
    w_kr_end   = (r_kr == RW'(K_R - 1));
    w_ks_end   = (r_ks == SW'(K_S - 1));
    w_ox_end   = (r_ox == (r_w - DIM_W'(1)));
    w_oy_end   = (r_oy == (r_h - DIM_W'(1)));
    w_last_tap = w_kr_end & w_ks_end;
    w_last_pix = w_last_tap & w_ox_end & w_oy_end;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort wins over start and over a same-edge handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          w_state_nxt = w_dims_ok ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hs && w_last_pix) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Tap / pixel counters, weight address and latched output dimensions.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      r_kr    <= '0;
      r_ks    <= '0;
      r_oy    <= '0;
      r_ox    <= '0;
      r_h     <= '0;
      r_w     <= '0;
      r_waddr <= '0;
    end else if (abort_i) begin
      r_kr    <= '0;
      r_ks    <= '0;
      r_oy    <= '0;
      r_ox    <= '0;
      r_waddr <= '0;
    end else if (w_start_ok) begin
      r_kr    <= '0;
      r_ks    <= '0;
      r_oy    <= '0;
      r_ox    <= '0;
      r_waddr <= '0;
      r_h     <= out_h_i;
      r_w     <= out_w_i;
    end else if (w_hs) begin
      if (w_last_tap) begin
        r_kr    <= '0;
        r_ks    <= '0;
        r_waddr <= '0;
        if (w_ox_end) begin
          r_ox <= '0;
          r_oy <= w_oy_end ? '0 : r_oy + DIM_W'(1);
        end else begin
          r_ox <= r_ox + DIM_W'(1);
        end
      end else begin
        r_waddr <= r_waddr + AW'(1);
        if (w_ks_end) begin
          r_ks <= '0;
          r_kr <= r_kr + RW'(1);
        end else begin
          r_ks <= r_ks + SW'(1);
        end
      end
    end
  end

`ifdef CONV_TAP_SCHED_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of offered-but-not-accepted descriptor cycles.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if (w_run && !tap_bus.tap_ready_i && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

  // Output decodes; last flags are gated so they read 0 outside RUN.
  assign tap_bus.tap_valid_o = w_run;
  assign tap_bus.w_addr_o    = r_waddr;
  assign tap_bus.kr_o        = r_kr;
  assign tap_bus.ks_o        = r_ks;
  assign tap_bus.oy_o        = r_oy;
  assign tap_bus.ox_o        = r_ox;
  assign tap_bus.last_tap_o  = w_run & w_last_tap;
  assign tap_bus.last_pix_o  = w_run & w_last_pix;
  assign busy_o              = (r_state != ST_IDLE);
  assign done_o              = (r_state == ST_DONE);
endmodule

// File: tb/tb_conv_tap_scheduler.sv
// Randomized self-checking bench for conv_tap_scheduler; the expected descriptor
// stream for a pass is built from nested loops over oy, ox, kr, ks.
`timescale 1ns/1ps
module tb_conv_tap_scheduler;
  localparam int unsigned K_R   = 3;
  localparam int unsigned K_S   = 3;
  localparam int unsigned DIM_W = 7;
  localparam int unsigned AW    = $clog2(K_R * K_S) + 1;
  localparam int unsigned RW    = $clog2(K_R) + 1;
  localparam int unsigned SW    = $clog2(K_S) + 1;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [RW-1:0]    kr;
    logic [SW-1:0]    ks;
    logic [DIM_W-1:0] oy;
    logic [DIM_W-1:0] ox;
    logic             lt;
    logic             lp;
  } desc_t;

  logic             clk_i = 1'b0;
  logic             rst_async_n_i;
  logic             start_i;
  logic             abort_i;
  logic [DIM_W-1:0] out_h_i;
  logic [DIM_W-1:0] out_w_i;
  logic             busy_o;
  logic             done_o;
`ifdef CONV_TAP_SCHED_STALL_CNT_EN
  logic [31:0]      stall_cnt_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  conv_tap_if #(.K_R(K_R), .K_S(K_S), .DIM_W(DIM_W)) bus ();

  conv_tap_scheduler #(.K_R(K_R), .K_S(K_S), .DIM_W(DIM_W)) dut (
    .clk_i        (clk_i),
    .rst_async_n_i(rst_async_n_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .out_h_i      (out_h_i),
    .out_w_i      (out_w_i),
    .tap_bus      (bus),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef CONV_TAP_SCHED_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic desc_t sample_bus();
    desc_t d;
    d.addr = bus.w_addr_o;
    d.kr   = bus.kr_o;
    d.ks   = bus.ks_o;
    d.oy   = bus.oy_o;
    d.ox   = bus.ox_o;
    d.lt   = bus.last_tap_o;
    d.lp   = bus.last_pix_o;
    return d;
  endfunction

  // Runs one pass: rmode 0 = ready always, 1 = ready toggles 1010 per offered
  // cycle, 2 = random. abort_at > 0 aborts on that handshake. poke pulses start
  // with different dims mid-pass.
  task automatic run_pass(input int h, input int w, input int rmode,
                          input int abort_at, input bit poke);
    desc_t q[$];
    desc_t e;
    desc_t got;
    int    hs       = 0;
    int    vcyc     = 0;
    int    stalls   = 0;
    bit    finished = 0;
    bit    aborted  = 0;
    bit    final_prev = 0;
    bit    rdy;
    bit    zero_dims = (h == 0) || (w == 0);

    for (int oy = 0; oy < h; oy++)
      for (int ox = 0; ox < w; ox++)
        for (int kr = 0; kr < int'(K_R); kr++)
          for (int ks = 0; ks < int'(K_S); ks++) begin
            e.addr = AW'(kr * int'(K_S) + ks);
            e.kr   = RW'(kr);
            e.ks   = SW'(ks);
            e.oy   = DIM_W'(oy);
            e.ox   = DIM_W'(ox);
            e.lt   = (kr == int'(K_R) - 1) && (ks == int'(K_S) - 1);
            e.lp   = e.lt && (ox == w - 1) && (oy == h - 1);
            q.push_back(e);
          end

    @(negedge clk_i);
    start_i = 1'b1;
    out_h_i = DIM_W'(h);
    out_w_i = DIM_W'(w);
    bus.tap_ready_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    out_h_i = DIM_W'($urandom_range(0, 127));
    out_w_i = DIM_W'($urandom_range(0, 127));

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      got = sample_bus();
      if (cyc == 0) begin
        n_checks++;
        if (bus.tap_valid_o !== !zero_dims)
          $display("FAIL first_valid h=%0d w=%0d got=%b exp=%b", h, w, bus.tap_valid_o, !zero_dims);
        else n_pass++;
      end
      if (final_prev) begin
        n_checks++;
        if (done_o !== 1'b1) $display("FAIL done_after_last got=%b exp=1", done_o);
        else n_pass++;
      end
      if (bus.tap_valid_o === 1'b1) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL extra_valid hs=%0d got=%h exp=none", hs, got);
        else if (got !== q[0] || busy_o !== 1'b1)
          $display("FAIL desc hs=%0d got=%h busy=%b exp=%h busy=1", hs, got, busy_o, q[0]);
        else n_pass++;
      end
      if (done_o === 1'b1) begin
        n_checks++;
        if (q.size() != 0 || !(final_prev || (cyc == 0 && zero_dims)) || bus.tap_valid_o !== 1'b0)
          $display("FAIL done_timing cyc=%0d left=%0d got=1 exp=0", cyc, q.size());
        else n_pass++;
        finished = 1;
      end
      if (!finished) begin
        case (rmode)
          0:       rdy = 1'b1;
          1:       rdy = (vcyc % 2) == 0;
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        start_i = 1'b0;
        if (poke && cyc == 3) begin
          start_i = 1'b1;
          out_h_i = DIM_W'(h + 1);
          out_w_i = DIM_W'(w + 2);
        end
        if (abort_at > 0 && bus.tap_valid_o === 1'b1 && hs == abort_at - 1) begin
          rdy = 1'b1;
          abort_i = 1'b1;
          aborted = 1;
        end
        bus.tap_ready_i = rdy;
        final_prev = 0;
        if (bus.tap_valid_o === 1'b1) begin
          vcyc++;
          if (rdy && !aborted) begin
            if (q.size() != 0) void'(q.pop_front());
            hs++;
            final_prev = (q.size() == 0);
          end else if (!rdy) begin
            stalls++;
          end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        abort_i = 1'b0;
        start_i = 1'b0;
        if (aborted) begin
          got = sample_bus();
          n_checks++;
          if (bus.tap_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || got !== '0)
            $display("FAIL abort_idle got valid=%b busy=%b done=%b desc=%h exp 0/0/0/0",
                     bus.tap_valid_o, busy_o, done_o, got);
          else n_pass++;
          for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            n_checks++;
            if (done_o !== 1'b0 || bus.tap_valid_o !== 1'b0)
              $display("FAIL abort_quiet got done=%b valid=%b exp 0/0", done_o, bus.tap_valid_o);
            else n_pass++;
          end
          finished = 1;
        end
      end
    end
    bus.tap_ready_i = 1'b0;

    n_checks++;
    if (!finished) $display("FAIL pass_timeout h=%0d w=%0d got=running exp=done", h, w);
    else n_pass++;

    if (!aborted) begin
      n_checks++;
      if (hs != h * w * int'(K_R * K_S))
        $display("FAIL hs_count got=%0d exp=%0d", hs, h * w * int'(K_R * K_S));
      else n_pass++;
      @(negedge clk_i);
      n_checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0)
        $display("FAIL done_one_cycle got done=%b busy=%b exp 0/0", done_o, busy_o);
      else n_pass++;
`ifdef CONV_TAP_SCHED_STALL_CNT_EN
      n_checks++;
      if (stall_cnt_o !== 32'(stalls)) $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt_o, stalls);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.tap_valid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || sample_bus() !== '0)
      $display("FAIL reset_state got valid=%b done=%b busy=%b desc=%h exp all 0",
               bus.tap_valid_o, done_o, busy_o, sample_bus());
    else n_pass++;
  endtask

  task automatic test_full_2x2();
    run_pass(2, 2, 0, 0, 1'b0);
  endtask

  task automatic test_stall_1x1();
    run_pass(1, 1, 1, 0, 1'b0);
  endtask

  task automatic test_zero_dim();
    run_pass(2, 0, 0, 0, 1'b0);
    run_pass(0, 3, 0, 0, 1'b0);
  endtask

  task automatic test_abort();
    run_pass(3, 3, 0, 20, 1'b0);
    run_pass(1, 1, 0, 0, 1'b0);
  endtask

  task automatic test_abort_start_idle();
    @(negedge clk_i);
    start_i = 1'b1;
    abort_i = 1'b1;
    out_h_i = DIM_W'(2);
    out_w_i = DIM_W'(2);
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    abort_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (busy_o !== 1'b0 || bus.tap_valid_o !== 1'b0 || done_o !== 1'b0)
        $display("FAIL abort_start_idle got busy=%b valid=%b done=%b exp 0/0/0",
                 busy_o, bus.tap_valid_o, done_o);
      else n_pass++;
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset_mid_pass();
    @(negedge clk_i);
    start_i = 1'b1;
    out_h_i = DIM_W'(2);
    out_w_i = DIM_W'(2);
    bus.tap_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2 rst_async_n_i = 1'b0;
    #1;
    n_checks++;
    if (bus.tap_valid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || sample_bus() !== '0)
      $display("FAIL reset_mid_pass got valid=%b done=%b busy=%b desc=%h exp all 0",
               bus.tap_valid_o, done_o, busy_o, sample_bus());
    else n_pass++;
    @(negedge clk_i);
    rst_async_n_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      n_checks++;
      if (bus.tap_valid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0)
        $display("FAIL post_reset_quiet got valid=%b done=%b busy=%b exp 0/0/0",
                 bus.tap_valid_o, done_o, busy_o);
      else n_pass++;
    end
    bus.tap_ready_i = 1'b0;
    run_pass(1, 2, 2, 0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_pass(2, 1, 2, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_pass(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2, 0, 1'b0);
  endtask

  initial begin
    rst_async_n_i   = 1'b0;
    start_i         = 1'b0;
    abort_i         = 1'b0;
    out_h_i         = '0;
    out_w_i         = '0;
    bus.tap_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    test_reset();
    rst_async_n_i = 1'b1;
    @(negedge clk_i);
    test_reset();
    test_full_2x2();
    test_stall_1x1();
    test_zero_dim();
    test_abort();
    test_abort_start_idle();
    test_reset_mid_pass();
    test_start_while_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
